router_in_arb: RTL

- Round-robin packet arbiter that shares the router's single input port (pkt_valid/data_in) among N_SRC upstream sources.
- Grants one source per packet. The grant is held from header through the parity byte.
- Source flow control comes from router busy. The block waits for the router to finish its parity check before it re-arbitrates.
- Sits directly in front of the router top, replacing the single-source stimulus.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_rr_pick.sv | 33 +++
 rtl/router_in_arb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router input-side arbiter.
// Header byte layout: destination address in the low bits, payload length above.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } arb_state_t;

  localparam int DEF_N_SRC  = 3;
  localparam int DEF_DATA_W = 8;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i,
// wrapping modulo N_SRC; pick_o is one-hot.
module router_rr_pick #(
  parameter int N_SRC = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N_SRC-1:0] pick_o,
  output logic             valid_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      // One extra bit so ptr+i cannot overflow before the modulo fold.
      sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_SRC)) sum = sum - (PTR_W+1)'(N_SRC);
      idx = sum[PTR_W-1:0];
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_in_arb.sv
// Round-robin packet arbiter sharing the router's single input port among
// N_SRC sources; a grant spans header through parity, then waits out busy.
module router_in_arb
  import router_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N_SRC-1:0]        src_pkt_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic [N_SRC-1:0]        src_grant,
  output logic [N_SRC-1:0]        src_abort,
  input  logic                    busy,
  input  logic                    soft_reset,
  output logic                    pkt_valid,
  output logic [DATA_W-1:0]       data_in,
  output logic                    pkt_done
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_t       state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hdr_sent_q, hdr_sent_d;
  logic [N_SRC-1:0] abort_q, abort_d;
  logic             done_q, done_d;

  logic [N_SRC-1:0]  pick;
  logic              pick_valid;
  logic [PTR_W-1:0]  g_idx;
  logic [PTR_W-1:0]  g_next;
  logic [DATA_W-1:0] src_bytes [N_SRC];

  router_rr_pick #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i    (src_pkt_valid),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .valid_o  (pick_valid)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_bytes[i] = src_data[i*DATA_W +: DATA_W];
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
    g_next = (g_idx == PTR_W'(N_SRC-1)) ? '0 : g_idx + 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    hdr_sent_d = hdr_sent_q;
    abort_d    = '0;
    done_d     = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = '0;
    src_ready  = '0;

    case (state_q)
      IDLE: begin
        if (!busy && pick_valid) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        pkt_valid = src_pkt_valid[g_idx];
        data_in   = src_bytes[g_idx];
        if (!busy) begin
          if (!hdr_sent_q) begin
            if (src_pkt_valid[g_idx]) begin
              src_ready[g_idx] = 1'b1;
              hdr_sent_d       = 1'b1;
            end else begin
              // Source withdrew before its header went out: release quietly.
              grant_d  = '0;
              rr_ptr_d = g_next;
              state_d  = IDLE;
            end
          end else begin
            src_ready[g_idx] = 1'b1;
            if (!src_pkt_valid[g_idx]) begin
              grant_d    = '0;
              hdr_sent_d = 1'b0;
              rr_ptr_d   = g_next;
              done_d     = 1'b1;
              state_d    = GAP;
            end
          end
        end
      end
      GAP: begin
        if (!busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Soft reset overrides everything above, including a same-cycle parity beat.
    if (soft_reset) begin
      state_d    = IDLE;
      grant_d    = '0;
      hdr_sent_d = 1'b0;
      done_d     = 1'b0;
      rr_ptr_d   = rr_ptr_q;
      if (|grant_q) begin
        abort_d  = grant_q;
        rr_ptr_d = g_next;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      hdr_sent_q <= 1'b0;
      abort_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      hdr_sent_q <= hdr_sent_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
    end
  end

  assign src_grant = grant_q;
  assign src_abort = abort_q;
  assign pkt_done  = done_q;

endmodule
